// File: rtl/n64_vdemux.sv
// N64 VDC bus front-end: samples the multiplexed data bus on the falling edge of nCLK
// and turns each sync/R/G/B group into one parallel pixel word with framing supervision.
module n64_vdemux #(
  parameter int COLOR_W = 7,
  parameter int GAP_MAX = 8
) (
  input  logic                     nCLK,
  input  logic                     RST,
  input  logic                     nDSYNC,
  input  logic [COLOR_W-1:0]       D_i,
  input  logic [4:0]               vinfo_i,
  input  logic                     deblur_en,
  output logic [3:0]               Sync_pre,
  output logic [3:0]               Sync_cur,
  output logic [4+3*COLOR_W-1:0]   vdata_o,
  output logic                     vdata_vld,
  output logic                     fmt_err_o,
  output logic                     desync_o
);

  localparam int               GAP_W   = $clog2(GAP_MAX + 1);
  localparam int               PIX_W   = 3 * COLOR_W;
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_MAX);

  typedef enum logic {ST_LOCKED = 1'b0, ST_UNLOCKED = 1'b1} state_t;

  // Slot that must follow a data slot carrying cnt; 2'b00 means the group is full.
  function automatic logic [1:0] next_slot(input logic [1:0] cnt);
    case (cnt)
      2'b01:   next_slot = 2'b10;
      2'b10:   next_slot = 2'b11;
      default: next_slot = 2'b00;
    endcase
  endfunction

  state_t             r_state, w_state_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_inc;
  logic               r_flag;
  logic [1:0]         r_nxt;
  logic [COLOR_W-1:0] r_r, r_g, r_b;
  logic [1:0]         w_cnt;
  logic               w_sync, w_done, w_emit, w_err, w_deblur;

  assign w_cnt     = vinfo_i[4:3];
  assign w_sync    = ~nDSYNC;
  assign w_done    = w_sync & r_flag & (w_cnt == 2'b11) & (r_nxt == 2'b00);
  assign w_deblur  = deblur_en & ~vinfo_i[2] & ~vinfo_i[0];
  assign w_gap_inc = (r_gap == GAP_LIM) ? r_gap : r_gap + GAP_W'(1);
  assign desync_o  = (r_state == ST_UNLOCKED);

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        w_emit = w_done;
        w_err  = w_sync & ~w_done;
        if (nDSYNC && (w_gap_inc == GAP_LIM)) w_state_nxt = ST_UNLOCKED;
      end
      ST_UNLOCKED: begin
        if (w_done) w_state_nxt = ST_LOCKED;
      end
    endcase
  end

  // Stage p0: framing control, gap supervision and output strobes
  always_ff @(negedge nCLK) begin
    if (RST) begin
      r_state   <= ST_UNLOCKED;
      r_gap     <= '0;
      r_flag    <= 1'b0;
      r_nxt     <= 2'b00;
      vdata_vld <= 1'b0;
      fmt_err_o <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      vdata_vld <= w_emit;
      fmt_err_o <= w_err;
      if (w_sync) begin
        r_gap  <= '0;
        r_flag <= 1'b1;
        r_nxt  <= 2'b01;
      end else begin
        r_gap <= w_gap_inc;
        if ((w_cnt != r_nxt) || (w_cnt == 2'b00)) r_flag <= 1'b0;
        r_nxt <= next_slot(w_cnt);
      end
    end
  end

  // Stage p1: colour capture and pixel assembly; de-blur freezes only the colour fields
  always_ff @(negedge nCLK) begin
    if (RST) begin
      Sync_pre <= 4'hF;
      Sync_cur <= 4'hF;
      vdata_o  <= {4'hF, {PIX_W{1'b0}}};
      r_r      <= '0;
      r_g      <= '0;
      r_b      <= '0;
    end else if (w_sync) begin
      Sync_pre <= Sync_cur;
      Sync_cur <= D_i[3:0];
      if (w_emit) begin
        if (w_deblur) vdata_o <= {Sync_cur, vdata_o[PIX_W-1:0]};
        else          vdata_o <= {Sync_cur, r_r, r_g, r_b};
      end
    end else begin
      case (w_cnt)
        2'b01:   r_r <= D_i;
        2'b10:   r_g <= D_i;
        2'b11:   r_b <= D_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_vdemux.sv
// Bench for n64_vdemux: directed scenarios plus randomized groups checked against
// a group-level reference model.
module tb_n64_vdemux;

  localparam int COLOR_W = 7;
  localparam int GAP_MAX = 8;
  localparam int W       = 4 + 3 * COLOR_W;

  logic               nCLK;
  logic               RST;
  logic               nDSYNC;
  logic [COLOR_W-1:0] D_i;
  logic [4:0]         vinfo_i;
  logic               deblur_en;
  logic [3:0]         Sync_pre, Sync_cur;
  logic [W-1:0]       vdata_o;
  logic               vdata_vld, fmt_err_o, desync_o;

  n64_vdemux #(.COLOR_W(COLOR_W), .GAP_MAX(GAP_MAX)) dut (
    .nCLK(nCLK), .RST(RST), .nDSYNC(nDSYNC), .D_i(D_i), .vinfo_i(vinfo_i),
    .deblur_en(deblur_en), .Sync_pre(Sync_pre), .Sync_cur(Sync_cur),
    .vdata_o(vdata_o), .vdata_vld(vdata_vld), .fmt_err_o(fmt_err_o), .desync_o(desync_o)
  );

  initial begin
    nCLK = 1'b1;
    forever #5 nCLK = ~nCLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  // extractor emulation and per-slot vinfo extras
  int t_run  = 0;
  bit vdeb   = 0;
  bit v480   = 0;
  bit vmode  = 0;
  bit vnblank = 0;

  // reference model state
  logic [3:0]   m_pre, m_cur;
  logic [W-1:0] m_vout;
  logic         m_vld, m_err, m_desync;
  logic [6:0]   m_r, m_g, m_b;
  int           m_gap;
  int           m_grp[$];
  bit           m_seen;

  typedef struct {bit rst; bit nd; logic [6:0] d; bit deb; bit n480; bit nblank;} stim_t;

  task automatic model_step(input bit rst, input bit nd, input logic [6:0] d, input logic [1:0] cnt);
    bit good;
    if (rst) begin
      m_pre = 4'hF; m_cur = 4'hF; m_vout = {4'hF, 21'd0};
      m_vld = 0; m_err = 0; m_desync = 1;
      m_r = 0; m_g = 0; m_b = 0; m_gap = 0; m_seen = 0;
      m_grp.delete();
    end else begin
      m_vld = 0; m_err = 0;
      if (!nd) begin
        good = m_seen && (m_grp.size() == 3) && (cnt == 2'd3);
        if (good) good = (m_grp[0] == 1) && (m_grp[1] == 2) && (m_grp[2] == 3);
        if (!m_desync) begin
          if (good) begin
            m_vld = 1;
            if (vdeb && !v480 && !vnblank) m_vout = {m_cur, m_vout[20:0]};
            else                           m_vout = {m_cur, m_r, m_g, m_b};
          end else begin
            m_err = 1;
          end
        end else if (good) begin
          m_desync = 0;
        end
        m_pre = m_cur; m_cur = d[3:0];
        m_grp.delete(); m_seen = 1; m_gap = 0;
      end else begin
        m_grp.push_back(int'(cnt));
        case (cnt)
          2'd1: m_r = d;
          2'd2: m_g = d;
          2'd3: m_b = d;
          default: ;
        endcase
        if (m_gap < GAP_MAX) m_gap++;
        if (m_gap == GAP_MAX) m_desync = 1;
      end
    end
  endtask

  // one nCLK falling edge; data_cnt is produced the way the extractor counts slots
  task automatic slot(input bit rst, input bit nd, input logic [6:0] d);
    logic [1:0] cnt;
    if (rst)      cnt = 2'd0;
    else if (!nd) cnt = t_run[1:0];
    else          cnt = 2'((t_run + 1) % 4);
    RST = rst; nDSYNC = nd; D_i = d;
    vinfo_i = {cnt, v480, vmode, vnblank};
    deblur_en = vdeb;
    @(negedge nCLK);
    model_step(rst, nd, d, cnt);
    if (rst || !nd) t_run = 0;
    else            t_run = (t_run + 1) % 4;
    #1;
  endtask

  task automatic send_rgb(input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    slot(0, 1, r); slot(0, 1, g); slot(0, 1, b);
  endtask

  task automatic test_reset;
    slot(1, 1, 7'h55);
    slot(1, 0, 7'h2A);
    n_checks++; if (Sync_pre !== 4'hF) begin n_errors++; $display("FAIL reset_pre got %h expected f", Sync_pre); end
    n_checks++; if (Sync_cur !== 4'hF) begin n_errors++; $display("FAIL reset_cur got %h expected f", Sync_cur); end
    n_checks++; if (vdata_o !== {4'hF, 21'd0}) begin n_errors++; $display("FAIL reset_vdata got %h expected %h", vdata_o, {4'hF, 21'd0}); end
    n_checks++; if (vdata_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld got %b expected 0", vdata_vld); end
    n_checks++; if (fmt_err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b expected 0", fmt_err_o); end
    n_checks++; if (desync_o !== 1'b1) begin n_errors++; $display("FAIL reset_desync got %b expected 1", desync_o); end
  endtask

  task automatic test_groups;
    int errs = 0;
    slot(0, 0, 7'h0E);
    errs += fmt_err_o;
    n_checks++; if (desync_o !== 1'b1) begin n_errors++; $display("FAIL grp_desync1 got %b expected 1", desync_o); end
    send_rgb(7'h11, 7'h22, 7'h33);
    slot(0, 0, 7'h0E);
    errs += fmt_err_o;
    n_checks++; if (desync_o !== 1'b0) begin n_errors++; $display("FAIL grp_desync2 got %b expected 0", desync_o); end
    n_checks++; if (vdata_vld !== 1'b0) begin n_errors++; $display("FAIL grp_vld2 got %b expected 0", vdata_vld); end
    send_rgb(7'h11, 7'h22, 7'h33);
    slot(0, 0, 7'h0E);
    errs += fmt_err_o;
    n_checks++; if (vdata_vld !== 1'b1) begin n_errors++; $display("FAIL grp_vld3 got %b expected 1", vdata_vld); end
    n_checks++; if (vdata_o !== {4'hE, 7'h11, 7'h22, 7'h33}) begin n_errors++; $display("FAIL grp_vdata got %h expected %h", vdata_o, {4'hE, 7'h11, 7'h22, 7'h33}); end
    slot(0, 1, 7'h11);
    errs += fmt_err_o;
    n_checks++; if (vdata_vld !== 1'b0) begin n_errors++; $display("FAIL grp_vld_strobe got %b expected 0", vdata_vld); end
    n_checks++; if (errs != 0) begin n_errors++; $display("FAIL grp_no_err got %0d expected 0", errs); end
  endtask

  task automatic test_short_group;
    slot(0, 1, 7'h22);
    slot(0, 1, 7'h33);
    slot(0, 0, 7'h0E);
    slot(0, 1, 7'h05);
    slot(0, 1, 7'h06);
    slot(0, 0, 7'h0A);
    n_checks++; if (fmt_err_o !== 1'b1) begin n_errors++; $display("FAIL short_err got %b expected 1", fmt_err_o); end
    n_checks++; if (vdata_o !== {4'hE, 7'h11, 7'h22, 7'h33}) begin n_errors++; $display("FAIL short_vdata got %h expected %h", vdata_o, {4'hE, 7'h11, 7'h22, 7'h33}); end
    n_checks++; if (Sync_cur !== 4'hA) begin n_errors++; $display("FAIL short_cur got %h expected a", Sync_cur); end
    n_checks++; if (vdata_vld !== 1'b0) begin n_errors++; $display("FAIL short_vld got %b expected 0", vdata_vld); end
    slot(0, 1, 7'h01);
    n_checks++; if (fmt_err_o !== 1'b0) begin n_errors++; $display("FAIL short_err_strobe got %b expected 0", fmt_err_o); end
    slot(0, 1, 7'h02); slot(0, 1, 7'h03);
  endtask

  task automatic test_sync_seq;
    slot(0, 0, 7'h0F);
    send_rgb(7'h01, 7'h02, 7'h03);
    slot(0, 0, 7'h07);
    n_checks++; if ({Sync_pre, Sync_cur} !== 8'hF7) begin n_errors++; $display("FAIL seq_f7 got %h expected f7", {Sync_pre, Sync_cur}); end
    send_rgb(7'h01, 7'h02, 7'h03);
    slot(0, 0, 7'h0F);
    n_checks++; if ({Sync_pre, Sync_cur} !== 8'h7F) begin n_errors++; $display("FAIL seq_7f got %h expected 7f", {Sync_pre, Sync_cur}); end
  endtask

  task automatic test_deblur;
    send_rgb(7'h01, 7'h02, 7'h03);
    slot(0, 0, 7'h03);
    send_rgb(7'h7F, 7'h7F, 7'h7F);
    vdeb = 1; v480 = 0; vnblank = 0;
    slot(0, 0, 7'h05);
    vdeb = 0;
    n_checks++; if (vdata_vld !== 1'b1) begin n_errors++; $display("FAIL deblur_vld got %b expected 1", vdata_vld); end
    n_checks++; if (vdata_o !== {4'h3, 7'h01, 7'h02, 7'h03}) begin n_errors++; $display("FAIL deblur_hold got %h expected %h", vdata_o, {4'h3, 7'h01, 7'h02, 7'h03}); end
    send_rgb(7'h7F, 7'h7F, 7'h7F);
    vdeb = 1; v480 = 1; vnblank = 0;
    slot(0, 0, 7'h06);
    vdeb = 0; v480 = 0;
    n_checks++; if (vdata_o !== {4'h5, 7'h7F, 7'h7F, 7'h7F}) begin n_errors++; $display("FAIL deblur_480i got %h expected %h", vdata_o, {4'h5, 7'h7F, 7'h7F, 7'h7F}); end
  endtask

  task automatic test_gap;
    int vlds = 0;
    for (int i = 1; i <= GAP_MAX; i++) begin
      slot(0, 1, 7'($urandom));
      vlds += vdata_vld;
      if (i == GAP_MAX - 1) begin
        n_checks++; if (desync_o !== 1'b0) begin n_errors++; $display("FAIL gap_early got %b expected 0", desync_o); end
      end
    end
    n_checks++; if (desync_o !== 1'b1) begin n_errors++; $display("FAIL gap_desync got %b expected 1", desync_o); end
    slot(0, 0, 7'h01);
    vlds += vdata_vld;
    n_checks++; if (fmt_err_o !== 1'b0) begin n_errors++; $display("FAIL gap_no_err got %b expected 0", fmt_err_o); end
    send_rgb(7'h31, 7'h32, 7'h33);
    slot(0, 0, 7'h02);
    vlds += vdata_vld;
    n_checks++; if (desync_o !== 1'b0) begin n_errors++; $display("FAIL gap_relock got %b expected 0", desync_o); end
    n_checks++; if (vlds != 0) begin n_errors++; $display("FAIL gap_vld_quiet got %0d expected 0", vlds); end
    send_rgb(7'h41, 7'h42, 7'h43);
    slot(0, 0, 7'h04);
    n_checks++; if (vdata_vld !== 1'b1) begin n_errors++; $display("FAIL gap_vld got %b expected 1", vdata_vld); end
    n_checks++; if (vdata_o !== {4'h2, 7'h41, 7'h42, 7'h43}) begin n_errors++; $display("FAIL gap_vdata got %h expected %h", vdata_o, {4'h2, 7'h41, 7'h42, 7'h43}); end
  endtask

  task automatic test_mid_reset;
    int hits = 0;
    slot(0, 1, 7'h51); slot(0, 1, 7'h52); slot(0, 1, 7'h53);
    slot(0, 0, 7'h09);
    slot(0, 1, 7'h10);
    slot(1, 1, 7'h20);
    n_checks++; if ({Sync_pre, Sync_cur} !== 8'hFF) begin n_errors++; $display("FAIL mrst_sync got %h expected ff", {Sync_pre, Sync_cur}); end
    n_checks++; if (vdata_o !== {4'hF, 21'd0}) begin n_errors++; $display("FAIL mrst_vdata got %h expected %h", vdata_o, {4'hF, 21'd0}); end
    n_checks++; if ({vdata_vld, fmt_err_o, desync_o} !== 3'b001) begin n_errors++; $display("FAIL mrst_ctl got %b expected 001", {vdata_vld, fmt_err_o, desync_o}); end
    slot(0, 1, 7'h30);
    hits += vdata_vld + fmt_err_o;
    slot(0, 0, 7'h0C);
    hits += vdata_vld + fmt_err_o;
    for (int i = 0; i < 3; i++) begin
      slot(0, 1, 7'(i + 1));
      hits += vdata_vld + fmt_err_o;
    end
    slot(0, 0, 7'h0C);
    hits += vdata_vld + fmt_err_o;
    n_checks++; if (hits != 0) begin n_errors++; $display("FAIL mrst_quiet got %0d expected 0", hits); end
  endtask

  task automatic test_random;
    stim_t q[$];
    stim_t s;
    int kind, n;
    s = '{rst: 1, nd: 1, d: 0, deb: 0, n480: 0, nblank: 0};
    q.push_back(s);
    for (int g = 0; g < 300; g++) begin
      kind = $urandom_range(0, 11);
      s.rst = 0; s.deb = 1'($urandom); s.n480 = 1'($urandom); s.nblank = 1'($urandom);
      if (kind == 11) begin s.rst = 1; s.nd = 1; s.d = 7'($urandom); q.push_back(s); s.rst = 0; end
      s.nd = 0; s.d = 7'($urandom); q.push_back(s);
      if (kind <= 6 || kind == 11) n = 3;
      else if (kind == 7) n = $urandom_range(0, 2);
      else if (kind == 8) n = $urandom_range(4, 5);
      else n = GAP_MAX + $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        s.nd = 1; s.d = 7'($urandom); q.push_back(s);
      end
    end
    foreach (q[i]) begin
      vdeb = q[i].deb; v480 = q[i].n480; vnblank = q[i].nblank; vmode = 1'($urandom);
      slot(q[i].rst, q[i].nd, q[i].d);
      n_checks++; if (Sync_pre !== m_pre) begin n_errors++; $display("FAIL rnd_pre @%0d got %h expected %h", i, Sync_pre, m_pre); end
      n_checks++; if (Sync_cur !== m_cur) begin n_errors++; $display("FAIL rnd_cur @%0d got %h expected %h", i, Sync_cur, m_cur); end
      n_checks++; if (vdata_o !== m_vout) begin n_errors++; $display("FAIL rnd_vdata @%0d got %h expected %h", i, vdata_o, m_vout); end
      n_checks++; if (vdata_vld !== m_vld) begin n_errors++; $display("FAIL rnd_vld @%0d got %b expected %b", i, vdata_vld, m_vld); end
      n_checks++; if (fmt_err_o !== m_err) begin n_errors++; $display("FAIL rnd_err @%0d got %b expected %b", i, fmt_err_o, m_err); end
      n_checks++; if (desync_o !== m_desync) begin n_errors++; $display("FAIL rnd_desync @%0d got %b expected %b", i, desync_o, m_desync); end
    end
    vdeb = 0; v480 = 0; vnblank = 0;
  endtask

  initial begin
    RST = 1; nDSYNC = 1; D_i = '0; vinfo_i = '0; deblur_en = 0;
    test_reset();
    test_groups();
    test_short_group();
    test_sync_seq();
    test_deblur();
    test_gap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
